// File: rtl/div_share_ctrl.sv
// Round-robin front end that lets NREQ requesters share one multi-cycle divider.
// Divide-by-zero is answered locally without starting the divider.
module div_share_ctrl #(
  parameter int N    = 24,
  parameter int NREQ = 4,
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*N-1:0] req_dividend,
  input  logic [NREQ*N-1:0] req_divisor,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [N-1:0]      rsp_quotient,
  output logic [N-1:0]      rsp_remainder,
  output logic              rsp_dbz,
  output logic              div_rst,
  output logic [N-1:0]      div_dividend,
  output logic [N-1:0]      div_divisor,
  input  logic [N-1:0]      div_quotient,
  input  logic [N-1:0]      div_remainder,
  input  logic              div_done,
  output logic [1:0]        dbg_state,
  output logic [IDW-1:0]    dbg_ptr
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  // Handshakes: a transfer happens on a rising clk edge where valid and ready
  // are both high; valid never waits on ready, ready may depend on valid.

  logic [1:0]     state;
  logic [IDW-1:0] ptr;
  logic [N-1:0]   lat_dividend;
  logic [N-1:0]   lat_divisor;
  logic           run_armed;

  logic           gnt_found;
  logic [IDW-1:0] gnt_id;
  logic [N-1:0]   sel_dividend;
  logic [N-1:0]   sel_divisor;

  // Scan upward from ptr, wrapping, and pick the first valid requester.
  always_comb begin
    int idx;
    idx          = 0;
    gnt_found    = 1'b0;
    gnt_id       = '0;
    sel_dividend = '0;
    sel_divisor  = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!gnt_found && req_valid[idx]) begin
        gnt_found    = 1'b1;
        gnt_id       = idx[IDW-1:0];
        sel_dividend = req_dividend[idx*N +: N];
        sel_divisor  = req_divisor[idx*N +: N];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == ST_IDLE && !rst && gnt_found) req_ready[gnt_id] = 1'b1;
  end

  assign rsp_valid    = (state == ST_RESP);
  assign div_rst      = rst | (state == ST_LOAD);
  assign div_dividend = lat_dividend;
  assign div_divisor  = lat_divisor;
  assign dbg_state    = state;
  assign dbg_ptr      = ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      ptr           <= '0;
      lat_dividend  <= '0;
      lat_divisor   <= '0;
      run_armed     <= 1'b0;
      rsp_id        <= '0;
      rsp_quotient  <= '0;
      rsp_remainder <= '0;
      rsp_dbz       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (gnt_found) begin
            lat_dividend <= sel_dividend;
            lat_divisor  <= sel_divisor;
            rsp_id       <= gnt_id;
            ptr          <= (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
            if (sel_divisor == '0) begin
              rsp_quotient  <= '1;
              rsp_remainder <= sel_dividend;
              rsp_dbz       <= 1'b1;
              state         <= ST_RESP;
            end else begin
              state <= ST_LOAD;
            end
          end
        end
        ST_LOAD: begin
          run_armed <= 1'b0;
          state     <= ST_RUN;
        end
        ST_RUN: begin
          // The first RUN cycle is skipped so a done level left over from the
          // previous job can never be mistaken for this one.
          run_armed <= 1'b1;
          if (run_armed && div_done) begin
            rsp_quotient  <= div_quotient;
            rsp_remainder <= div_remainder;
            rsp_dbz       <= 1'b0;
            state         <= ST_RESP;
          end
        end
        default: begin
          if (rsp_ready) state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_share_ctrl.sv
// Directed bench for div_share_ctrl with an N-cycle behavioural divider model.
module tb_div_share_ctrl;
  localparam int N    = 24;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*N-1:0] req_dividend;
  logic [NREQ*N-1:0] req_divisor;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [N-1:0]      rsp_quotient;
  logic [N-1:0]      rsp_remainder;
  logic              rsp_dbz;
  logic              div_rst;
  logic [N-1:0]      div_dividend;
  logic [N-1:0]      div_divisor;
  logic [N-1:0]      div_quotient;
  logic [N-1:0]      div_remainder;
  logic              div_done;
  logic [1:0]        dbg_state;
  logic [IDW-1:0]    dbg_ptr;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int div_rst_pulses = 0;

  div_share_ctrl #(.N(N), .NREQ(NREQ)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_dividend(req_dividend), .req_divisor(req_divisor),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_quotient(rsp_quotient), .rsp_remainder(rsp_remainder), .rsp_dbz(rsp_dbz),
    .div_rst(div_rst), .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_quotient(div_quotient), .div_remainder(div_remainder), .div_done(div_done),
    .dbg_state(dbg_state), .dbg_ptr(dbg_ptr)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (div_rst && !rst) div_rst_pulses <= div_rst_pulses + 1;
  end

  // Divider model: done rises N clock edges after the load pulse ends.
  int  dcnt;
  logic dbusy;
  always @(posedge clk) begin
    if (div_rst) begin
      dcnt     <= 0;
      dbusy    <= 1'b1;
      div_done <= 1'b0;
    end else if (dbusy) begin
      dcnt <= dcnt + 1;
      if (dcnt == N - 1) begin
        dbusy    <= 1'b0;
        div_done <= 1'b1;
        div_quotient  <= (div_divisor == '0) ? '1 : div_dividend / div_divisor;
        div_remainder <= (div_divisor == '0) ? div_dividend : div_dividend % div_divisor;
      end
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [N-1:0] dvd, input logic [N-1:0] dvs);
    req_dividend[i*N +: N] = dvd;
    req_divisor[i*N +: N]  = dvs;
    req_valid[i]           = 1'b1;
  endtask

  // Called in the cycle after the accept edge; returns cycles since accept.
  task automatic wait_rsp(output int lat);
    lat = 1;
    while (!rsp_valid && lat < 200) begin
      tick();
      lat++;
    end
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  int lat;
  int pulses_before;
  int t_acc[3];
  int exp_order[8];
  int wait_cnt;

  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_dividend = '0;
    req_divisor = '0;
    rsp_ready = 1'b0;
    #1;
    req_valid = '1;
    #1;
    check("rst_req_ready", 32'(req_ready), 32'h0);
    check("rst_div_rst", 32'(div_rst), 32'h1);
    tick();
    tick();
    req_valid = '0;
    rst = 1'b0;
    #1;
    check("reset_state", 32'(dbg_state), 32'h0);
    check("reset_ptr", 32'(dbg_ptr), 32'h0);
    check("reset_rsp_valid", 32'(rsp_valid), 32'h0);
    check("reset_quot", 32'(rsp_quotient), 32'h0);
    check("reset_rem", 32'(rsp_remainder), 32'h0);
    check("reset_dbz", 32'(rsp_dbz), 32'h0);
    check("reset_div_rst", 32'(div_rst), 32'h0);

    // 1000/10 from req0: response 27 cycles after accept
    set_req(0, 24'd1000, 24'd10);
    #1;
    check("t1_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    check("t1_load_div_rst", 32'(div_rst), 32'h1);
    check("t1_div_dividend", 32'(div_dividend), 32'd1000);
    wait_rsp(lat);
    check("t1_latency", 32'(lat), 32'd27);
    check("t1_id", 32'(rsp_id), 32'd0);
    check("t1_quot", 32'(rsp_quotient), 32'd100);
    check("t1_rem", 32'(rsp_remainder), 32'd0);
    check("t1_dbz", 32'(rsp_dbz), 32'd0);
    handshake();

    // 50/0 from req1: answered next cycle, divider untouched
    pulses_before = div_rst_pulses;
    set_req(1, 24'd50, 24'd0);
    #1;
    check("t2_ready", 32'(req_ready), 32'h2);
    tick();
    req_valid = '0;
    check("t2_valid_next", 32'(rsp_valid), 32'h1);
    check("t2_id", 32'(rsp_id), 32'd1);
    check("t2_quot", 32'(rsp_quotient), 32'hFFFFFF);
    check("t2_rem", 32'(rsp_remainder), 32'd50);
    check("t2_dbz", 32'(rsp_dbz), 32'd1);
    handshake();
    tick();
    check("t2_no_div_rst", 32'(div_rst_pulses), 32'(pulses_before));

    // Round robin: all four held, then req0 and req2 held
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_order = '{0, 1, 2, 3, 0, 2, 0, 2};
    for (int i = 0; i < NREQ; i++) set_req(i, 24'(i * 7 + 3), 24'd0);
    for (int k = 0; k < 8; k++) begin
      if (k == 4) begin
        req_valid = 4'b0101;
      end
      #1;
      check($sformatf("t3_grant%0d", k), 32'(req_ready), 32'(1 << exp_order[k]));
      tick();
      check($sformatf("t3_id%0d", k), 32'(rsp_id), 32'(exp_order[k]));
      check($sformatf("t3_rem%0d", k), 32'(rsp_remainder), 32'(exp_order[k] * 7 + 3));
      handshake();
    end
    req_valid = '0;

    // Backpressure: 16777215/255 held for 10 cycles with rsp_ready low
    set_req(0, 24'd16777215, 24'd255);
    #1;
    check("t4_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    wait_rsp(lat);
    check("t4_latency", 32'(lat), 32'd27);
    req_valid[1] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      check($sformatf("t4_valid%0d", k), 32'(rsp_valid), 32'h1);
      check($sformatf("t4_quot%0d", k), 32'(rsp_quotient), 32'd65793);
      check($sformatf("t4_rem%0d", k), 32'(rsp_remainder), 32'd0);
      check($sformatf("t4_rdy%0d", k), 32'(req_ready), 32'h0);
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    check("t4_hs_no_accept", 32'(req_ready), 32'h0);
    tick();
    rsp_ready = 1'b0;
    check("t4_idle", 32'(dbg_state), 32'h0);
    check("t4_rsp_low", 32'(rsp_valid), 32'h0);
    check("t4_next_grant", 32'(req_ready), 32'h2);
    req_valid = '0;

    // Reset mid-RUN, then 5000000/123
    set_req(2, 24'd1000, 24'd10);
    tick();
    req_valid = '0;
    for (int k = 0; k < 10; k++) tick();
    check("t5_in_run", 32'(dbg_state), 32'h2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_state", 32'(dbg_state), 32'h0);
    check("t5_rsp_valid", 32'(rsp_valid), 32'h0);
    check("t5_ptr", 32'(dbg_ptr), 32'h0);
    set_req(3, 24'd5000000, 24'd123);
    #1;
    check("t5_ready", 32'(req_ready), 32'h8);
    tick();
    req_valid = '0;
    wait_rsp(lat);
    check("t5_latency", 32'(lat), 32'd27);
    check("t5_id", 32'(rsp_id), 32'd3);
    check("t5_quot", 32'(rsp_quotient), 32'd40650);
    check("t5_rem", 32'(rsp_remainder), 32'd50);
    handshake();

    // Back-to-back with rsp_ready tied high: accepts every N+4 cycles
    rsp_ready = 1'b1;
    set_req(2, 24'd1000, 24'd7);
    for (int k = 0; k < 3; k++) begin
      wait_cnt = 0;
      while (!req_ready[2] && wait_cnt < 100) begin
        tick();
        wait_cnt++;
      end
      t_acc[k] = cyc;
      tick();
    end
    req_valid = '0;
    check("t6_gap1", 32'(t_acc[1] - t_acc[0]), 32'd28);
    check("t6_gap2", 32'(t_acc[2] - t_acc[1]), 32'd28);
    wait_rsp(lat);
    check("t6_quot", 32'(rsp_quotient), 32'd142);
    check("t6_rem", 32'(rsp_remainder), 32'd6);
    tick();
    rsp_ready = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule
